imm_ext_unit: RTL and testbench

- Immediate extender for the 32-bit MIPS-style datapath.
- Takes the 16-bit instruction immediate and produces a 32-bit operand for the ALU, branch-target adder or LUI path, selected by a 2-bit EXTOp.
- Output is registered: one clock, asynchronous active-low reset, with a simple valid qualifier so the decode stage can stall it.

---
 rtl/imm_ext_unit.sv | 63 ++++++
 tb/tb_imm_ext_unit.sv | 128 ++++++++++++
 2 files changed

// File: rtl/imm_ext_unit.sv
// Registered immediate extender: zero/sign/load-upper/branch-offset modes, 1-cycle latency.
// Optional macro EXT_COMB_OUT_EN adds the combinational bypass output EXTcomb.
module imm_ext_unit #(
   parameter int IMM_W    = 16,
   parameter int OUT_W    = 32,   // must be at least 2*IMM_W
   parameter int BR_SHIFT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [IMM_W-1:0] imm,
   input  logic [1:0]       EXTOp,
   output logic             out_valid,
   output logic [OUT_W-1:0] EXTout
`ifdef EXT_COMB_OUT_EN
   ,
   output logic [OUT_W-1:0] EXTcomb
`endif
);

   typedef enum logic [1:0] {
      EXT_ZERO   = 2'b00,
      EXT_SIGN   = 2'b01,
      EXT_UPPER  = 2'b10,
      EXT_BRANCH = 2'b11
   } ext_op_e;

   logic [OUT_W-1:0] sext_val;
   logic [OUT_W-1:0] ext_val;

   assign sext_val = {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
   always_comb begin
      ext_val = '0;
      unique case (ext_op_e'(EXTOp))
         EXT_ZERO:   ext_val[IMM_W-1:0]       = imm;
         EXT_SIGN:   ext_val                  = sext_val;
         EXT_UPPER:  ext_val[2*IMM_W-1:IMM_W] = imm;
         EXT_BRANCH: ext_val                  = sext_val << BR_SHIFT;
         default:    ext_val                  = '0;
      endcase
   end

   // Result register holds its value across idle cycles; only out_valid drops.
   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         EXTout    <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            EXTout <= ext_val;
         end
      end
   end

`ifdef EXT_COMB_OUT_EN
   assign EXTcomb = ext_val;
`endif

endmodule

// File: tb/tb_imm_ext_unit.sv
// Directed, table-driven bench for imm_ext_unit, plus reset, hold and mid-stream reset sequences.
module tb_imm_ext_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] imm;
   logic [1:0]  EXTOp;
   logic        out_valid;
   logic [31:0] EXTout;
`ifdef EXT_COMB_OUT_EN
   logic [31:0] EXTcomb;
`endif

   int checks = 0;
   int errors = 0;

   imm_ext_unit #(.IMM_W(16), .OUT_W(32), .BR_SHIFT(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .imm       (imm),
      .EXTOp     (EXTOp),
      .out_valid (out_valid),
      .EXTout    (EXTout)
`ifdef EXT_COMB_OUT_EN
      ,
      .EXTcomb   (EXTcomb)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] imm;
      logic [1:0]  op;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive a stream of vectors with in_valid held high; each result is checked one edge later.
   task automatic run_stream(input string tag, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         imm      = vecs[i].imm;
         EXTOp    = vecs[i].op;
         in_valid = 1'b1;
`ifdef EXT_COMB_OUT_EN
         #1;
         check($sformatf("%s_comb[%0d]", tag, i), EXTcomb, vecs[i].exp);
`endif
         @(negedge clk);
         check($sformatf("%s_out[%0d]", tag, i), EXTout, vecs[i].exp);
         check($sformatf("%s_valid[%0d]", tag, i), {31'd0, out_valid}, 32'd1);
      end
   endtask

   initial begin
      vecs[0]  = '{16'hFFF8, 2'b00, 32'h0000FFF8};
      vecs[1]  = '{16'hFFF8, 2'b01, 32'hFFFFFFF8};
      vecs[2]  = '{16'hFFF8, 2'b10, 32'hFFF80000};
      vecs[3]  = '{16'hFFF8, 2'b11, 32'hFFFFFFE0};
      vecs[4]  = '{16'h1234, 2'b01, 32'h00001234};
      vecs[5]  = '{16'h1234, 2'b11, 32'h000048D0};
      vecs[6]  = '{16'h1234, 2'b10, 32'h12340000};
      vecs[7]  = '{16'h8001, 2'b00, 32'h00008001};
      vecs[8]  = '{16'h8001, 2'b01, 32'hFFFF8001};
      vecs[9]  = '{16'h8001, 2'b10, 32'h80010000};
      vecs[10] = '{16'h8001, 2'b11, 32'hFFFE0004};

      // Reset held with valid input present: outputs stay cleared across edges.
      rst_n    = 1'b0;
      in_valid = 1'b1;
      imm      = 16'hFFF8;
      EXTOp    = 2'b01;
      repeat (2) @(negedge clk);
      check("reset_out", EXTout, 32'h0);
      check("reset_valid", {31'd0, out_valid}, 32'd0);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      check("idle_after_reset", {31'd0, out_valid}, 32'd0);

      run_stream("table", 0, 6);

      // Hold: capture, then go idle and wiggle the inputs.
      imm = 16'h7FFF; EXTOp = 2'b01; in_valid = 1'b1;
      @(negedge clk);
      check("hold_capture", EXTout, 32'h00007FFF);
      in_valid = 1'b0; imm = 16'hAAAA; EXTOp = 2'b10;
      @(negedge clk);
      check("hold_out", EXTout, 32'h00007FFF);
      check("hold_valid", {31'd0, out_valid}, 32'd0);
      EXTOp = 2'b11; imm = 16'h5555;
      @(negedge clk);
      check("hold_out2", EXTout, 32'h00007FFF);

      run_stream("stream", 7, 10);

      // Mid-stream reset clears outputs asynchronously and beats in_valid at the edge.
      imm = 16'hFFF8; EXTOp = 2'b00; in_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_out", EXTout, 32'h0);
      check("async_reset_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      check("reset_wins_out", EXTout, 32'h0);
      check("reset_wins_valid", {31'd0, out_valid}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("first_capture_out", EXTout, 32'h0000FFF8);
      check("first_capture_valid", {31'd0, out_valid}, 32'd1);
      in_valid = 1'b0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
